pipe_stage_buf: RTL

//  Parametrised ID->EX pipeline stage: a generic payload bundle crosses with a

---
 rtl/pipe_stage_buf_pkg.sv | 39 +++
 rtl/pipe_stage_buf_sat_counter.sv | 23 ++
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared ID->EX pipeline types: payload bundle, its NOP encoding and the
// controller's hold levels.
package riscv_pipe_pkg;

  localparam int HOLD_BUS_W = 3;

  localparam logic [HOLD_BUS_W-1:0] HOLD_NONE  = 3'd0;
  localparam logic [HOLD_BUS_W-1:0] HOLD_PC    = 3'd1;
  localparam logic [HOLD_BUS_W-1:0] HOLD_IF_ID = 3'd2;
  localparam logic [HOLD_BUS_W-1:0] HOLD_ID_EX = 3'd3;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [47:0] offset;
    logic [31:0] inst;
    logic [38:0] inst_addr;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic        csr_wen;
    logic [63:0] csr_rdata;
    logic [11:0] csr_waddr;
  } id_ex_payload_t;

  localparam int ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

  localparam id_ex_payload_t ID_EX_NOP = '{
    op1: '0, op2: '0, offset: '0, inst: INST_NOP, inst_addr: '0,
    reg_wen: 1'b0, reg_waddr: '0, csr_wen: 1'b0, csr_rdata: '0, csr_waddr: '0
  };

  function automatic logic hold_active(input logic [HOLD_BUS_W-1:0] level,
                                       input logic [HOLD_BUS_W-1:0] thresh);
    return level >= thresh;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the stage's performance statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// ID->EX pipeline stage: valid/ready handshake with optional 2-entry skid,
// freeze or bubble hold behaviour, flush, and stall/flush statistics.
module pipe_stage_buf
  import riscv_pipe_pkg::*;
#(
  parameter int                    PAYLOAD_W   = ID_EX_PAYLOAD_W,
  parameter logic [PAYLOAD_W-1:0]  NOP_PAYLOAD = ID_EX_NOP,
  parameter bit                    SKID_EN     = 1'b1,
  parameter bit                    HOLD_MODE   = 1'b1,
  parameter logic [HOLD_BUS_W-1:0] HOLD_THRESH = HOLD_ID_EX,
  parameter int                    CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [HOLD_BUS_W-1:0] hold_flag_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PAYLOAD_W-1:0]  in_payload_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PAYLOAD_W-1:0]  out_payload_o,
  output logic [1:0]            occupancy_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  logic                 r_main_valid, r_skid_valid, r_ready;
  logic [PAYLOAD_W-1:0] r_main, r_skid;
  logic [1:0]           r_occ;

  logic                 w_main_valid_next, w_skid_valid_next, w_ready_next;
  logic [PAYLOAD_W-1:0] w_main_next, w_skid_next;
  logic [1:0]           w_occ_next;

  logic w_hold_en, w_in_ready, w_out_valid, w_in_fire, w_out_fire, w_stall_inc;

  assign w_hold_en = hold_active(hold_flag_i, HOLD_THRESH);

  generate
    if (SKID_EN && !HOLD_MODE) begin : g_illegal_cfg
      $error("pipe_stage_buf: SKID_EN=1 requires HOLD_MODE=1");
    end

    if (SKID_EN) begin : g_ready_skid
      assign w_in_ready = r_ready & ~w_hold_en;
    end else begin : g_ready_direct
      // Without a skid slot, ready must look through to the consumer.
      assign w_in_ready = ~w_hold_en & (~r_main_valid | out_ready_i);
    end

    if (HOLD_MODE) begin : g_valid_freeze
      assign w_out_valid = r_main_valid & ~w_hold_en;
    end else begin : g_valid_bubble
      assign w_out_valid = r_main_valid;
    end
  endgenerate

  assign w_in_fire  = in_valid_i & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready_i;

  always_comb begin
    w_main_next       = r_main;
    w_main_valid_next = r_main_valid;
    w_skid_next       = r_skid;
    w_skid_valid_next = r_skid_valid;
    if (flush_i) begin
      w_main_next       = NOP_PAYLOAD;
      w_main_valid_next = 1'b0;
      w_skid_next       = NOP_PAYLOAD;
      w_skid_valid_next = 1'b0;
    end else if (w_hold_en) begin
      if (!HOLD_MODE) begin
        w_main_next       = NOP_PAYLOAD;
        w_main_valid_next = 1'b0;
      end
    end else begin
      case ({r_main_valid, r_skid_valid})
        2'b00: begin
          if (w_in_fire) begin
            w_main_next       = in_payload_i;
            w_main_valid_next = 1'b1;
          end
        end
        2'b10: begin
          if (w_in_fire && w_out_fire) begin
            w_main_next = in_payload_i;
          end else if (w_in_fire) begin
            w_skid_next       = in_payload_i;
            w_skid_valid_next = 1'b1;
          end else if (w_out_fire) begin
            w_main_next       = NOP_PAYLOAD;
            w_main_valid_next = 1'b0;
          end
        end
        2'b11: begin
          if (w_out_fire) begin
            w_main_next       = r_skid;
            w_skid_next       = NOP_PAYLOAD;
            w_skid_valid_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
    w_occ_next   = {1'b0, w_main_valid_next} + {1'b0, w_skid_valid_next};
    w_ready_next = (w_occ_next != 2'd2);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_main       <= NOP_PAYLOAD;
      r_main_valid <= 1'b0;
      r_skid       <= NOP_PAYLOAD;
      r_skid_valid <= 1'b0;
      r_occ        <= 2'd0;
      r_ready      <= 1'b1;
    end else begin
      r_main       <= w_main_next;
      r_main_valid <= w_main_valid_next;
      r_skid       <= w_skid_next;
      r_skid_valid <= w_skid_valid_next;
      r_occ        <= w_occ_next;
      r_ready      <= w_ready_next;
    end
  end

  assign w_stall_inc = w_hold_en | (r_main_valid & ~out_ready_i);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_stall_inc),
    .cnt_o   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_i),
    .cnt_o   (flush_cnt_o)
  );

  assign in_ready_o    = w_in_ready;
  assign out_valid_o   = w_out_valid;
  assign out_payload_o = r_main;
  assign occupancy_o   = r_occ;

endmodule
